mac_tx: RTL and testbench
=========================

Name: mac_tx

Overview:
- Ethernet MAC transmit stage, directly downstream of the IP transmit layer.
- Grants the upper layer's send request and requests frame bytes at a fixed offset.
- Prepends preamble and SFD, pads to the minimum frame size, and appends the CRC-32 FCS.
- Drives the GMII transmit interface, enforces the inter-frame gap, then signals send completion.

Parameters:
- MIN_FRAME_LEN, 60: minimum bytes between SFD and FCS; zero-pad until reached.
- MAX_FRAME_LEN, 1514: maximum bytes between SFD and FCS; longer frames are truncated.
- IFG_CYCLES, 12: idle cycles after the last FCS byte before completion.
- READY_TIMEOUT, 16'hffff: cycles to wait for mac_tx_ready before abandoning a grant.

Ports:
- clk  in  1  system clock (GMII tx clock domain)
- rst_n  in  1  asynchronous active-low reset
- mac_tx_req  in  1  upper layer wants to send (level)
- mac_tx_ack  out  1  one-cycle grant pulse
- mac_tx_ready  in  1  upper layer has header/length ready
- mac_data_req  out  1  one-cycle pulse; upper layer streams bytes starting 2 cycles later
- mac_frame_data  in  8  frame byte (dest MAC first … payload)
- mac_tx_end  in  1  high coincident with last upstream byte
- mac_send_end  out  1  one-cycle pulse: frame plus IFG complete
- mac_tx_busy  out  1  high in any state but IDLE
- gmii_tx_en  out  1  GMII transmit enable
- gmii_txd  out  8  GMII transmit data

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 32'hFFFF_FFFF; counters 0.
- All outputs are registered. Reset mid-frame drops gmii_tx_en the same cycle with no FCS. After reset release, start again from IDLE.
- IDLE:
  - mac_tx_req=1 → ACK.
- ACK:
  - mac_tx_ack=1 for exactly one cycle, then → WAIT_READY.
- WAIT_READY:
  - mac_tx_ready=1 → PREAMBLE.
  - Timeout counter reaches READY_TIMEOUT → IDLE, no mac_send_end.
  - Counter clears when leaving this state.
- PREAMBLE, first gmii_tx_en cycle = P:
  - gmii_txd=8'h55 at P..P+6; 8'hD5 at P+7.
  - mac_data_req pulses at P+5.
  - Byte 0 is sampled at P+7 and driven at P+8 (1-cycle input-to-gmii pipeline). At P+7 → DATA.
- DATA:
  - Each sampled byte is driven next cycle; CRC is updated with it; byte_cnt increments.
  - mac_tx_end sampled with a byte makes that byte the last.
    - byte_cnt < MIN_FRAME_LEN → PAD.
    - Otherwise → FCS.
  - byte_cnt reaches MAX_FRAME_LEN without mac_tx_end → FCS. Remaining upstream bytes are ignored.
- PAD:
  - Drive 8'h00, CRC-included, until byte_cnt == MIN_FRAME_LEN, then → FCS.
- FCS:
  - 4 bytes of ~CRC, least-significant byte first (reflected IEEE 802.3, poly 32'h04C11DB7, init all ones).
  - gmii_tx_en stays 1 through the last FCS byte, then 0.
- IFG:
  - gmii_tx_en=0, gmii_txd=0 for IFG_CYCLES, then → END.
- END:
  - mac_send_end=1 for one cycle → IDLE.
  - mac_tx_req still high re-enters ACK next cycle (no starvation logic; single client).
- Widths:
  - byte_cnt 11 bits, saturates at MAX_FRAME_LEN.
  - Timeout counter 16 bits.
- Simultaneous events:
  - mac_tx_req during any non-IDLE state is ignored until IDLE.
  - mac_tx_end outside DATA is ignored.
  - mac_tx_ready and timeout in the same cycle: ready wins.

Decomposition:
- Package mac_pkg holds:
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5.
  - CRC32_POLY, CRC32_INIT.
  - Default MIN/MAX frame lengths and IFG.
  - State encoding constants (one-hot, 9 states: IDLE, ACK, WAIT_READY, PREAMBLE, DATA, PAD, FCS, IFG, END).
- Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]), LSB-first reflected. mac_tx owns the CRC register.

Test Plan:
- CRC vector, MIN_FRAME_LEN=0: send ASCII "123456789" with mac_tx_end on '9' → gmii: 7×55, D5, 31..39, then 26 39 F4 CB; mac_send_end 12 cycles after CB.
- Minimum padding, default params: 42-byte frame → 18 bytes of 00 after byte 41; 60 data bytes total, then 4 FCS bytes matching a software CRC.
- Handshake timing: mac_tx_req=1 → mac_tx_ack one pulse; mac_tx_ready → gmii_tx_en rises next cycle; mac_data_req at 6th preamble byte; byte 0 appears immediately after D5.
- Timeout: grant, never assert mac_tx_ready → IDLE after 65535 cycles; gmii_tx_en never 1; no mac_send_end.
- Oversize: 1600 bytes with no mac_tx_end → exactly 1514 data bytes then FCS; later bytes ignored.
- Reset mid-DATA: rst_n=0 at byte 20 → gmii_tx_en=0 immediately. After release, a new request produces a correct full frame.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared constants for the Ethernet MAC transmit stage:
//   - GMII framing bytes (preamble, SFD)
//   - CRC-32 polynomial / initial value and a bit-reverse helper
//   - default frame-length limits, inter-frame gap and ready timeout
//   - one-hot state encoding of the transmit FSM
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

    localparam int          DEF_MIN_FRAME_LEN = 60;
    localparam int          DEF_MAX_FRAME_LEN = 1514;
    localparam int          DEF_IFG_CYCLES    = 12;
    localparam logic [15:0] DEF_READY_TIMEOUT = 16'hFFFF;

    typedef enum logic [8:0] {
        ST_IDLE       = 9'b0_0000_0001,
        ST_ACK        = 9'b0_0000_0010,
        ST_WAIT_READY = 9'b0_0000_0100,
        ST_PREAMBLE   = 9'b0_0000_1000,
        ST_DATA       = 9'b0_0001_0000,
        ST_PAD        = 9'b0_0010_0000,
        ST_FCS        = 9'b0_0100_0000,
        ST_IFG        = 9'b0_1000_0000,
        ST_END        = 9'b1_0000_0000
    } state_t;

    // Bit-reverse a 32-bit word; turns the normal-form polynomial into the
    // form used by an LSB-first shift register.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Combinational one-byte step of the IEEE 802.3 CRC-32, processed LSB first
// (reflected form). The caller owns the CRC register and the final inversion.
// Ports:
//   crc_in  [31:0]  current CRC register value
//   data    [7:0]   byte to absorb, bit 0 enters first
//   crc_out [31:0]  CRC register value after absorbing data
// -----------------------------------------------------------------------------
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mac_tx.sv
// -----------------------------------------------------------------------------
// mac_tx
// Ethernet MAC transmit stage. Grants the upper layer's send request, requests
// the frame bytes, prepends preamble/SFD, zero-pads short frames, truncates
// long ones, appends the CRC-32 FCS, drives GMII and enforces the inter-frame
// gap before reporting completion. Every output is a flop.
// Ports:
//   clk, rst_n       GMII tx clock, asynchronous active-low reset
//   mac_tx_req       upper layer wants to send (level)
//   mac_tx_ack       one-cycle grant pulse
//   mac_tx_ready     upper layer has header/length ready
//   mac_data_req     one-cycle pulse; byte 0 must be presented two cycles later
//   mac_frame_data   upstream frame byte
//   mac_tx_end       marks the last upstream byte
//   mac_send_end     one-cycle pulse once frame and IFG are complete
//   mac_tx_busy      high whenever the FSM is not idle
//   gmii_tx_en/txd   GMII transmit interface
// -----------------------------------------------------------------------------
module mac_tx
    import mac_pkg::*;
#(
    parameter int          MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
    parameter int          MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
    parameter int          IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter logic [15:0] READY_TIMEOUT = DEF_READY_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mac_tx_req,
    output logic       mac_tx_ack,
    input  logic       mac_tx_ready,
    output logic       mac_data_req,
    input  logic [7:0] mac_frame_data,
    input  logic       mac_tx_end,
    output logic       mac_send_end,
    output logic       mac_tx_busy,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd
);

    localparam logic [10:0] MIN_CNT   = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_CNT   = 11'(MAX_FRAME_LEN);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);
    // Preamble phase numbers, counted from the first gmii_tx_en cycle.
    // Outputs are registered, so each phase decides what goes out next cycle.
    localparam logic [15:0] PRE_DREQ  = 16'd4;
    localparam logic [15:0] PRE_SFD   = 16'd6;

    state_t      state_q, state_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [15:0] phase_q, phase_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] byte_inc;
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_next;
    logic [31:0] fcs_word;
    logic [7:0]  crc_byte;
    logic        take_byte;

    logic        ack_q, ack_d;
    logic        data_req_q, data_req_d;
    logic        send_end_q, send_end_d;
    logic        busy_q, busy_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  txd_q, txd_d;

    // Padding bytes are zeros that still enter the CRC.
    assign crc_byte = (state_q == ST_PAD) ? 8'h00 : mac_frame_data;
    assign fcs_word = ~crc_q;
    assign byte_inc = (byte_cnt_q >= MAX_CNT) ? MAX_CNT : byte_cnt_q + 11'd1;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        ack_d      = 1'b0;
        data_req_d = 1'b0;
        send_end_d = 1'b0;
        tx_en_d    = 1'b0;
        txd_d      = 8'h00;
        take_byte  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mac_tx_req) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end

            ST_ACK: begin
                state_d  = ST_WAIT_READY;
                to_cnt_d = '0;
            end

            ST_WAIT_READY: begin
                // Ready is tested first so it wins over a coincident timeout.
                if (mac_tx_ready) begin
                    state_d    = ST_PREAMBLE;
                    to_cnt_d   = '0;
                    phase_d    = '0;
                    byte_cnt_d = '0;
                    crc_d      = CRC32_INIT;
                    tx_en_d    = 1'b1;
                    txd_d      = PREAMBLE_BYTE;
                end else if (to_cnt_q + 16'd1 == READY_TIMEOUT) begin
                    state_d  = ST_IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end

            ST_PREAMBLE: begin
                tx_en_d    = 1'b1;
                phase_d    = phase_q + 16'd1;
                data_req_d = (phase_q == PRE_DREQ);
                if (phase_q < PRE_SFD) begin
                    txd_d = PREAMBLE_BYTE;
                end else if (phase_q == PRE_SFD) begin
                    txd_d = SFD_BYTE;
                end else begin
                    // SFD is on the wire now; byte 0 arrives this cycle.
                    take_byte = 1'b1;
                end
            end

            ST_DATA: begin
                tx_en_d   = 1'b1;
                take_byte = 1'b1;
            end

            ST_PAD: begin
                tx_en_d    = 1'b1;
                txd_d      = 8'h00;
                crc_d      = crc_next;
                byte_cnt_d = byte_inc;
                if (byte_inc >= MIN_CNT) begin
                    state_d = ST_FCS;
                    phase_d = '0;
                end
            end

            ST_FCS: begin
                tx_en_d = 1'b1;
                phase_d = phase_q + 16'd1;
                case (phase_q[1:0])
                    2'd0:    txd_d = fcs_word[7:0];
                    2'd1:    txd_d = fcs_word[15:8];
                    2'd2:    txd_d = fcs_word[23:16];
                    default: txd_d = fcs_word[31:24];
                endcase
                if (phase_q[1:0] == 2'd3) begin
                    state_d = ST_IFG;
                    phase_d = '0;
                end
            end

            ST_IFG: begin
                // The first IFG state cycle still shows the last FCS byte,
                // so the wire is idle for exactly IFG_CYCLES cycles before END.
                if (phase_q == IFG_LAST) begin
                    state_d    = ST_END;
                    phase_d    = '0;
                    send_end_d = 1'b1;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared handling of an upstream byte: forward it next cycle, fold it
        // into the CRC and decide whether the payload is finished.
        if (take_byte) begin
            txd_d      = mac_frame_data;
            crc_d      = crc_next;
            byte_cnt_d = byte_inc;
            phase_d    = '0;
            if (mac_tx_end) begin
                state_d = (byte_inc < MIN_CNT) ? ST_PAD : ST_FCS;
            end else if (byte_inc >= MAX_CNT) begin
                state_d = ST_FCS;
            end else begin
                state_d = ST_DATA;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            phase_q    <= '0;
            byte_cnt_q <= '0;
            crc_q      <= CRC32_INIT;
            ack_q      <= 1'b0;
            data_req_q <= 1'b0;
            send_end_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            txd_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            ack_q      <= ack_d;
            data_req_q <= data_req_d;
            send_end_q <= send_end_d;
            busy_q     <= busy_d;
            tx_en_q    <= tx_en_d;
            txd_q      <= txd_d;
        end
    end

    assign mac_tx_ack   = ack_q;
    assign mac_data_req = data_req_q;
    assign mac_send_end = send_end_q;
    assign mac_tx_busy  = busy_q;
    assign gmii_tx_en   = tx_en_q;
    assign gmii_txd     = txd_q;

endmodule

// File: tb/tb_mac_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mac_tx
// Two instances: u_dut0 with default parameters, u_dut1 with MIN_FRAME_LEN=0.
// Stimulus pushes the expected GMII byte stream and a completion token into
// queues; a monitor pops and compares whenever a DUT drives GMII or pulses
// mac_send_end.
// -----------------------------------------------------------------------------
module tb_mac_tx;

    localparam int IFG  = 12;
    localparam int MAXL = 1514;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req      [2];
    logic       ready    [2];
    logic       tend     [2];
    logic [7:0] fdata    [2];
    logic       ack      [2];
    logic       dreq     [2];
    logic       send_end [2];
    logic       busy     [2];
    logic       tx_en    [2];
    logic [7:0] txd      [2];

    mac_tx u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .mac_tx_req(req[0]), .mac_tx_ack(ack[0]), .mac_tx_ready(ready[0]),
        .mac_data_req(dreq[0]), .mac_frame_data(fdata[0]), .mac_tx_end(tend[0]),
        .mac_send_end(send_end[0]), .mac_tx_busy(busy[0]),
        .gmii_tx_en(tx_en[0]), .gmii_txd(txd[0])
    );

    mac_tx #(.MIN_FRAME_LEN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .mac_tx_req(req[1]), .mac_tx_ack(ack[1]), .mac_tx_ready(ready[1]),
        .mac_data_req(dreq[1]), .mac_frame_data(fdata[1]), .mac_tx_end(tend[1]),
        .mac_send_end(send_end[1]), .mac_tx_busy(busy[1]),
        .gmii_tx_en(tx_en[1]), .gmii_txd(txd[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_q    [$];
    int          exp_done [$];
    logic [7:0]  payload  [$];
    logic [31:0] crc_tbl  [256];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic build_crc_table();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
            crc_tbl[n] = c;
        end
    endtask

    // Expected wire image: preamble, SFD, payload truncated to MAXL and
    // zero-padded to min_len, then the inverted CRC low byte first.
    task automatic push_expected(input int min_len);
        logic [31:0] c;
        logic [7:0]  b;
        int          n;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        n = (payload.size() > MAXL) ? MAXL : payload.size();
        for (int i = 0; (i < n) || (i < min_len); i++) begin
            b = (i < n) ? payload[i] : 8'h00;
            exp_q.push_back(b);
            c = (c >> 8) ^ crc_tbl[c[7:0] ^ b];
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        exp_done.push_back(1);
    endtask

    task automatic fill_random(input int len);
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
    endtask

    // ---------------- monitor / scoreboard ----------------
    int in_frame  [2];
    int start_cyc [2];
    int last_cyc  [2];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) in_frame[i] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (tx_en[i]) begin
                    if (in_frame[i] == 0) begin
                        in_frame[i]  = 1;
                        start_cyc[i] = cyc;
                    end
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL gmii_extra_byte: inst %0d drove 0x%02h, nothing expected", i, txd[i]);
                    end else begin
                        check("gmii_txd", int'(txd[i]), int'(exp_q.pop_front()));
                    end
                end else begin
                    if (in_frame[i] != 0) begin
                        in_frame[i] = 0;
                        last_cyc[i] = cyc - 1;
                    end
                    check("gmii_txd_idle", int'(txd[i]), 0);
                end
                if (dreq[i]) begin
                    check("data_req_offset", (in_frame[i] != 0) ? cyc - start_cyc[i] : -1, 5);
                end
                if (send_end[i]) begin
                    if (exp_done.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL send_end_unexpected: inst %0d pulsed mac_send_end, none expected", i);
                    end else begin
                        void'(exp_done.pop_front());
                        check("ifg_gap", cyc - last_cyc[i], IFG);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle", int'(busy[i]), 0);
    endtask

    task automatic send_frame(input int i, input bit give_end, input int abort_at);
        int n;
        wait_idle(i);
        req[i] = 1'b1;
        @(posedge clk); #1;
        check("ack_pulse", int'(ack[i]), 1);
        req[i] = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", int'(ack[i]), 0);
        check("busy_wait_ready", int'(busy[i]), 1);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        ready[i] = 1'b1;
        @(posedge clk); #1;
        ready[i] = 1'b0;
        check("tx_en_rise", int'(tx_en[i]), 1);
        n = 0;
        while (!dreq[i] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("data_req_delay", n, 5);
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < payload.size(); k++) begin
            if (k == abort_at) begin
                check("tx_en_before_reset", int'(tx_en[i]), 1);
                rst_n = 1'b0;
                #1;
                check("reset_drops_tx_en", int'(tx_en[i]), 0);
                check("reset_busy", int'(busy[i]), 0);
                exp_q.delete();
                exp_done.delete();
                break;
            end
            fdata[i] = payload[k];
            tend[i]  = give_end && (k == payload.size() - 1);
            @(posedge clk); #1;
        end
        fdata[i] = 8'h00;
        tend[i]  = 1'b0;
        if (abort_at >= 0) begin
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end
        wait_idle(i);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        build_crc_table();
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; ready[i] = 1'b0; tend[i] = 1'b0; fdata[i] = 8'h00;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ack",      int'(ack[i]), 0);
            check("rst_data_req", int'(dreq[i]), 0);
            check("rst_send_end", int'(send_end[i]), 0);
            check("rst_busy",     int'(busy[i]), 0);
            check("rst_tx_en",    int'(tx_en[i]), 0);
            check("rst_txd",      int'(txd[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Standard check string "123456789" with no padding.
        payload.delete();
        for (int k = 0; k < 9; k++) payload.push_back(8'(8'h31 + k));
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 9; k++) exp_q.push_back(8'(8'h31 + k));
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        exp_done.push_back(1);
        send_frame(1, 1'b1, -1);

        // 42-byte frame padded to 60.
        fill_random(42);
        push_expected(60);
        send_frame(0, 1'b1, -1);

        for (int f = 0; f < 10; f++) begin
            fill_random($urandom_range(1, 100));
            push_expected(60);
            send_frame(0, 1'b1, -1);
        end
        for (int f = 0; f < 6; f++) begin
            fill_random($urandom_range(1, 80));
            push_expected(0);
            send_frame(1, 1'b1, -1);
        end

        // Oversize frame without an end marker.
        fill_random(1600);
        push_expected(60);
        send_frame(0, 1'b0, -1);

        // Reset at byte 20, then a clean frame.
        fill_random(50);
        push_expected(60);
        send_frame(0, 1'b1, 20);
        fill_random(70);
        push_expected(60);
        send_frame(0, 1'b1, -1);

        // Grant without ready: abandoned after the timeout.
        req[0] = 1'b1;
        @(posedge clk); #1;
        check("timeout_ack", int'(ack[0]), 1);
        req[0] = 1'b0;
        n = 0;
        while (n < 70000) begin
            @(posedge clk); #1;
            if (!busy[0]) break;
            n++;
        end
        check("timeout_cycles", n, 65535);
        repeat (4) @(posedge clk);
        #1;

        check("exp_bytes_drained", exp_q.size(), 0);
        check("exp_frames_drained", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
